// File: rtl/shift_frame_register.sv
// shift_frame_register: parallel-load / serial-shift frame register.
// Transmit word is loaded by handshake; the received word is offered by handshake.
module shift_frame_register #(
    parameter int   Width      = 8,
    parameter logic ResetValue = 1'b0,
    parameter bit   MsbFirst   = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       serial_in,
    output logic                       serial_out,
    input  logic                       enable,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [Width-1:0]           load_data,
    output logic                       frame_valid,
    input  logic                       frame_ready,
    output logic [Width-1:0]           frame_data,
    output logic [$clog2(Width+1)-1:0] bit_count,
    output logic                       busy
);
    localparam int CW = $clog2(Width + 1);
    localparam logic [CW-1:0] LastCount = CW'(Width - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [Width-1:0] r_shift;
    logic [Width-1:0] w_shifted;
    logic [CW-1:0]    r_count;
    logic             w_load;
    logic             w_step;

    assign busy        = r_state == SHIFT;
    assign frame_valid = r_state == HOLD;
    assign load_ready  = (r_state == IDLE) | (frame_valid & frame_ready);
    assign frame_data  = r_shift;
    assign bit_count   = r_count;
    assign w_load      = load_valid & load_ready;
    assign w_step      = busy & enable;
    assign w_shifted   = MsbFirst ? {r_shift[Width-2:0], serial_in} : {serial_in, r_shift[Width-1:1]};
    // Outside SHIFT the line idles at the fill level.
    assign serial_out  = busy ? (MsbFirst ? r_shift[Width-1] : r_shift[0]) : ResetValue;

    always_comb begin
        w_next = r_state;
        if (w_load)
            w_next = SHIFT;
        else if (w_step && r_count == LastCount)
            w_next = HOLD;
        else if (frame_valid && frame_ready)
            w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= {Width{ResetValue}};
            r_count <= '0;
        end else if (w_load) begin
            r_shift <= load_data;
            r_count <= '0;
        end else if (w_step) begin
            r_shift <= w_shifted;
            r_count <= r_count + CW'(1);
        end
    end
endmodule
